// File: rtl/multicycle_datapath.sv
// Multicycle datapath: register file, sign-extender, ALU and writeback mux
// sequenced by a five-state FSM. Data memory is external behind req/ack.
module multicycle_datapath #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                reg_wr,
    input  logic [1:0]          reg_dst,
    input  logic [2:0]          alu_ctrl,
    input  logic                mem_wr,
    input  logic                mem_to_reg,
    input  logic                alu_src,
    input  logic                wb_sel,
    input  logic [15:0]         imm16,
    input  logic [REG_BITS-1:0] rs,
    input  logic [REG_BITS-1:0] rt,
    input  logic [REG_BITS-1:0] rd,
    input  logic [WIDTH-1:0]    link_data,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic [WIDTH-1:0]    da,
    output logic                alu_zero,
    output logic                alu_overflow,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WIDTH-1:0]    mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    input  logic                mem_ack
);

    localparam int NREGS = 1 << REG_BITS;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Instruction fields captured when start is accepted
    logic                r_reg_wr;
    logic [1:0]          r_reg_dst;
    logic [2:0]          r_alu_ctrl;
    logic                r_mem_wr;
    logic                r_mem_to_reg;
    logic                r_alu_src;
    logic                r_wb_sel;
    logic [15:0]         r_imm16;
    logic [REG_BITS-1:0] r_rs;
    logic [REG_BITS-1:0] r_rt;
    logic [REG_BITS-1:0] r_rd;
    logic [WIDTH-1:0]    r_link;

    // Operand / result registers
    logic signed [WIDTH-1:0] r_da;
    logic signed [WIDTH-1:0] r_db;
    logic signed [WIDTH-1:0] r_sext;
    logic [WIDTH-1:0]        r_result;
    logic [WIDTH-1:0]        r_mem_addr;
    logic                    r_zero;
    logic                    r_ovf;

    logic [WIDTH-1:0] r_regs [NREGS];

    logic signed [WIDTH-1:0] w_b;
    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_diff;
    logic                    w_lt;
    logic [WIDTH-1:0]        w_alu_res;
    logic                    w_alu_ovf;
    logic [REG_BITS-1:0]     w_dst;
    logic [WIDTH-1:0]        w_wb_data;
    logic [WIDTH-1:0]        w_rs_val;
    logic [WIDTH-1:0]        w_rt_val;
    logic                    w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    // Register 0 is hardwired to zero on the read side
    assign w_rs_val = (r_rs == '0) ? '0 : r_regs[r_rs];
    assign w_rt_val = (r_rt == '0) ? '0 : r_regs[r_rt];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; memory state waits on ack for arbitrary latency
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = (r_mem_wr || r_mem_to_reg) ? S_MEM : S_WB;
            S_MEM:    if (mem_ack) w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ALU: wrapping add/sub, signed overflow only for add/sub, true signed SLT
    always_comb begin
        w_b       = r_alu_src ? r_sext : r_db;
        w_sum     = r_da + w_b;
        w_diff    = r_da - w_b;
        w_lt      = r_da < w_b;
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (r_alu_ctrl)
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (r_da[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_da[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (r_da[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_da[WIDTH-1]);
            end
            OP_XOR:  w_alu_res = r_da ^ w_b;
            OP_SLT:  w_alu_res = WIDTH'(w_lt);
            OP_AND:  w_alu_res = r_da & w_b;
            OP_NAND: w_alu_res = ~(r_da & w_b);
            OP_NOR:  w_alu_res = ~(r_da | w_b);
            OP_OR:   w_alu_res = r_da | w_b;
            default: w_alu_res = '0;
        endcase
    end

    // Destination select and writeback mux; 2 and 3 both select the link register
    always_comb begin
        case (r_reg_dst)
            2'd0:    w_dst = r_rd;
            2'd1:    w_dst = r_rt;
            default: w_dst = {REG_BITS{1'b1}};
        endcase
        w_wb_data = r_wb_sel ? r_link : r_result;
    end

    // Capture the instruction fields so later input changes cannot disturb the op
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_wr     <= 1'b0;
            r_reg_dst    <= '0;
            r_alu_ctrl   <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_wb_sel     <= 1'b0;
            r_imm16      <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_link       <= '0;
        end else if (w_accept) begin
            r_reg_wr     <= reg_wr;
            r_reg_dst    <= reg_dst;
            r_alu_ctrl   <= alu_ctrl;
            r_mem_wr     <= mem_wr;
            r_mem_to_reg <= mem_to_reg;
            r_alu_src    <= alu_src;
            r_wb_sel     <= wb_sel;
            r_imm16      <= imm16;
            r_rs         <= rs;
            r_rt         <= rt;
            r_rd         <= rd;
            r_link       <= link_data;
        end
    end

    // Operand latch at DECODE, ALU latch at EXEC, load data capture on ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_da       <= '0;
            r_db       <= '0;
            r_sext     <= '0;
            r_result   <= '0;
            r_mem_addr <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_DECODE: begin
                    r_da   <= w_rs_val;
                    r_db   <= w_rt_val;
                    r_sext <= WIDTH'($signed(r_imm16));
                end
                S_EXEC: begin
                    r_result   <= w_alu_res;
                    r_mem_addr <= w_alu_res;
                    r_zero     <= (w_alu_res == '0);
                    r_ovf      <= w_alu_ovf;
                end
                S_MEM: begin
                    if (mem_ack && r_mem_to_reg && !r_mem_wr) begin
                        r_result <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file write at the closing edge of WB; writes to register 0 dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == S_WB) && r_reg_wr && (w_dst != '0)) begin
            r_regs[w_dst] <= w_wb_data;
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_WB);
    assign mem_req      = (r_state == S_MEM);
    assign mem_we       = (r_state == S_MEM) && r_mem_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_db;
    assign result       = r_result;
    assign da           = r_da;
    assign alu_zero     = r_zero;
    assign alu_overflow = r_ovf;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: stimulus pushes expected WB results,
// a negedge monitor pops them when done is seen; a memory responder models ack latency.
module tb_multicycle_datapath;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SLT = 3'd3,
                           AND = 3'd4, NAND = 3'd5, NOR = 3'd6, OR = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        reg_wr = 1'b0;
    logic [1:0]  reg_dst = '0;
    logic [2:0]  alu_ctrl = '0;
    logic        mem_wr = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic        alu_src = 1'b0;
    logic        wb_sel = 1'b0;
    logic [15:0] imm16 = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [31:0] link_data = '0;
    logic        busy, done;
    logic [31:0] result, da;
    logic        alu_zero, alu_overflow;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    multicycle_datapath #(.WIDTH(32), .REG_BITS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .alu_ctrl(alu_ctrl), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .wb_sel(wb_sel), .imm16(imm16), .rs(rs), .rt(rt), .rd(rd), .link_data(link_data),
        .busy(busy), .done(done), .result(result), .da(da), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;
    exp_t q[$];

    // memory responder configuration
    bit          resp_en = 1'b1;
    int          ack_delay = 0;
    logic [31:0] rdata_val = '0;
    logic [31:0] exp_addr = '0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_wdata = '0;
    int          req_cnt = 0;
    int          last_req_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("alu_overflow", 32'(alu_overflow), 32'(e.ovf));
                chk("alu_zero", 32'(alu_zero), 32'(e.zero));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("mem_req_in_wb", 32'(mem_req), 32'd0);
            end
        end
    end

    // memory responder: acks ack_delay cycles after MEM entry, checks request stability
    always @(negedge clk) begin
        if (reset) begin
            mem_ack = 1'b0;
            req_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && resp_en) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_wdata", mem_wdata, exp_wdata);
            if (req_cnt == ack_delay) begin
                mem_ack = 1'b1;
                mem_rdata = rdata_val;
                last_req_len = req_cnt + 1;
                req_cnt = 0;
            end else begin
                req_cnt++;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic [4:0] a_rd, input logic [1:0] dst, input logic wr,
                         input logic asrc, input logic [15:0] imm, input logic mw, input logic mr,
                         input logic wsel, input logic [31:0] link, input logic [31:0] er,
                         input logic eo, input logic ez, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        alu_ctrl = op; rs = a_rs; rt = a_rt; rd = a_rd; reg_dst = dst; reg_wr = wr;
        alu_src = asrc; imm16 = imm; mem_wr = mw; mem_to_reg = mr; wb_sel = wsel;
        link_data = link; start = 1'b1;
        e.res = er; e.ovf = eo; e.zero = ez; e.cyc = cyc + lat;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // scramble fields: the op in flight must not see these
        rs = rs + 5'd1; rt = rt + 5'd1; rd = rd + 5'd1; alu_ctrl = alu_ctrl + 3'd1;
        imm16 = ~imm16; alu_src = ~alu_src; wb_sel = ~wb_sel; link_data = ~link_data;
        reg_dst = reg_dst + 2'd1; mem_wr = ~mem_wr; mem_to_reg = ~mem_to_reg;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) chk("wait_done_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic rd_reg(input logic [4:0] r, input logic [31:0] v);
        issue(ADD, r, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              v, 1'b0, (v == 32'h0), 3, 1'b1);
        wait_done();
        wait_idle();
    endtask

    task automatic alu_op(input logic [2:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                          input logic [31:0] er, input logic eo, input logic ez);
        issue(op, a_rs, a_rt, 5'd9, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              er, eo, ez, 3, 1'b1);
        wait_done();
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_da", da, 32'd0);
        chk("rst_flags", {30'd0, alu_zero, alu_overflow}, 32'd0);
        chk("rst_mem", {30'd0, mem_req, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // read an untouched register with rs=rt
        alu_op(ADD, 5'd5, 5'd5, 32'h0, 1'b0, 1'b1);

        // preset R1 = 0x7FFFFFFF by a load from 0x10, ack same cycle
        exp_addr = 32'h10; exp_we = 1'b0; exp_wdata = 32'h0; ack_delay = 0; rdata_val = 32'h7FFFFFFF;
        issue(ADD, 5'd0, 5'd1, 5'd0, 2'd1, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 32'h0,
              32'h7FFFFFFF, 1'b0, 1'b0, 4, 1'b1);
        wait_done(); wait_idle();
        // R2 = 1
        issue(ADD, 5'd0, 5'd0, 5'd2, 2'd0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h1, 1'b0, 1'b0, 3, 1'b1);
        wait_done(); wait_idle();

        // R3 = R1 + R2 overflows; then read R3 back-to-back
        issue(ADD, 5'd1, 5'd2, 5'd3, 2'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h80000000, 1'b1, 1'b0, 3, 1'b1);
        wait_done();
        issue(ADD, 5'd3, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h80000000, 1'b0, 1'b0, 3, 1'b1);
        wait_done(); wait_idle();
        chk("da_latched", da, 32'h80000000);

        // remaining ALU ops
        alu_op(SUB,  5'd3, 5'd2, 32'h7FFFFFFF, 1'b1, 1'b0);
        alu_op(SLT,  5'd3, 5'd2, 32'h1,        1'b0, 1'b0);
        alu_op(SLT,  5'd1, 5'd3, 32'h0,        1'b0, 1'b1);
        alu_op(XOR,  5'd1, 5'd2, 32'h7FFFFFFE, 1'b0, 1'b0);
        alu_op(AND,  5'd1, 5'd3, 32'h0,        1'b0, 1'b1);
        alu_op(NAND, 5'd1, 5'd2, 32'hFFFFFFFE, 1'b0, 1'b0);
        alu_op(NOR,  5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        alu_op(OR,   5'd1, 5'd3, 32'hFFFFFFFF, 1'b0, 1'b0);

        // sign extension: R4 = 0x100, then R4 + sext(0xFFFC) = 0xFC
        issue(ADD, 5'd0, 5'd0, 5'd4, 2'd0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h100, 1'b0, 1'b0, 3, 1'b1);
        wait_done(); wait_idle();
        issue(ADD, 5'd4, 5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b0, 32'h0,
              32'hFC, 1'b0, 1'b0, 3, 1'b1);
        wait_done(); wait_idle();

        // load from 0x40 with ack 3 cycles late into R6
        issue(ADD, 5'd0, 5'd0, 5'd5, 2'd0, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h40, 1'b0, 1'b0, 3, 1'b1);
        wait_done(); wait_idle();
        exp_addr = 32'h40; exp_we = 1'b0; exp_wdata = 32'h0; ack_delay = 3; rdata_val = 32'hDEADBEEF;
        issue(ADD, 5'd5, 5'd6, 5'd0, 2'd1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0,
              32'hDEADBEEF, 1'b0, 1'b0, 7, 1'b1);
        wait_done(); wait_idle();
        chk("load_req_len", 32'(last_req_len), 32'd4);
        rd_reg(5'd6, 32'hDEADBEEF);

        // mem_wr and mem_to_reg together is a store; result keeps ALU value
        exp_addr = 32'h44; exp_we = 1'b1; exp_wdata = 32'h1; ack_delay = 1; rdata_val = 32'hAAAA5555;
        issue(ADD, 5'd5, 5'd2, 5'd0, 2'd0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, 32'h0,
              32'h44, 1'b0, 1'b0, 5, 1'b1);
        wait_done(); wait_idle();
        chk("store_req_len", 32'(last_req_len), 32'd2);

        // link write to R31
        issue(ADD, 5'd0, 5'd0, 5'd7, 2'd2, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'h1234,
              32'h0, 1'b0, 1'b1, 3, 1'b1);
        wait_done(); wait_idle();
        rd_reg(5'd31, 32'h1234);

        // write to R0 is discarded
        issue(ADD, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h55, 1'b0, 1'b0, 3, 1'b1);
        wait_done(); wait_idle();
        rd_reg(5'd0, 32'h0);

        // start held during DECODE and EXEC is ignored
        issue(ADD, 5'd1, 5'd2, 5'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h80000000, 1'b1, 1'b0, 3, 1'b1);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("busy_ignored_start", 32'(busy), 32'd0);

        // reset during MEM aborts the load into R7
        resp_en = 1'b0;
        issue(ADD, 5'd5, 5'd7, 5'd0, 2'd1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0,
              32'h0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (mem_req) break;
            @(negedge clk);
        end
        chk("mem_req_seen", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        resp_en = 1'b1;
        rd_reg(5'd7, 32'h0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
